// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: multi-panel LED matrix scan engine.
// A frame is shifted serially into a shadow buffer. On commit, the shadow
// buffer is swapped into the active buffer at the end of the current frame.
// Panels and columns are then time-multiplexed, with blanking between columns.
// Optional per-frame brightness gating is enabled by defining LED_SCAN_BRIGHTNESS_EN.
module led_matrix_scanner #(
  parameter int NUM_PANELS   = 2,
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int SCAN_DIV     = 16384,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       shift_en,
  input  logic                       shift_data,
  input  logic                       commit,
`ifdef LED_SCAN_BRIGHTNESS_EN
  input  logic [3:0]                 brightness,
`endif
  output logic                       shift_ready,
  output logic                       frame_err,
  output logic                       frame_start,
  output logic [ROWS-1:0]            row,
  output logic [NUM_PANELS*COLS-1:0] col
);

  localparam int FRAME_BITS = NUM_PANELS * COLS * ROWS;
  localparam int NUM_COLS   = NUM_PANELS * COLS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam int PANEL_W    = (NUM_PANELS > 1) ? $clog2(NUM_PANELS) : 1;
  localparam int COL_W      = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SEL_W      = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int DWELL_W    = $clog2(SCAN_DIV);
  localparam int BLANK_W    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  typedef enum logic {S_BLANK, S_ON} state_t;

  state_t                state_q, state_d;
  logic [PANEL_W-1:0]    panel_idx_q, panel_idx_d;
  logic [COL_W-1:0]      col_idx_q, col_idx_d;
  logic [DWELL_W-1:0]    dwell_cnt_q, dwell_cnt_d;
  logic [BLANK_W-1:0]    blank_cnt_q, blank_cnt_d;
  logic [FRAME_BITS-1:0] shadow_q, shadow_d;
  logic [FRAME_BITS-1:0] active_q, active_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  pending_q, pending_d;
  logic                  shift_ready_q, shift_ready_d;
  logic                  frame_err_q, frame_err_d;
  logic                  frame_start_q, frame_start_d;
  logic [ROWS-1:0]       row_q, row_d;
  logic [NUM_COLS-1:0]   col_q, col_d;
  logic                  swap;
  logic                  lit;
  logic [SEL_W-1:0]      sel;

  // Scan sequencing: blank/on phases, column and panel stepping, frame boundary
  always_comb begin
    state_d       = state_q;
    panel_idx_d   = panel_idx_q;
    col_idx_d     = col_idx_q;
    dwell_cnt_d   = dwell_cnt_q;
    blank_cnt_d   = blank_cnt_q;
    frame_start_d = 1'b0;
    swap          = 1'b0;
    case (state_q)
      S_BLANK: begin
        if (blank_cnt_q == BLANK_W'(BLANK_CYCLES - 1)) begin
          state_d     = S_ON;
          blank_cnt_d = '0;
          dwell_cnt_d = '0;
        end else begin
          blank_cnt_d = blank_cnt_q + 1'b1;
        end
      end
      S_ON: begin
        if (dwell_cnt_q == DWELL_W'(SCAN_DIV - 1)) begin
          state_d     = S_BLANK;
          dwell_cnt_d = '0;
          blank_cnt_d = '0;
          if (col_idx_q == COL_W'(COLS - 1)) begin
            col_idx_d = '0;
            if (panel_idx_q == PANEL_W'(NUM_PANELS - 1)) begin
              panel_idx_d   = '0;
              frame_start_d = 1'b1;
              swap          = pending_q;
            end else begin
              panel_idx_d = panel_idx_q + 1'b1;
            end
          end else begin
            col_idx_d = col_idx_q + 1'b1;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q + 1'b1;
        end
      end
      default: state_d = S_BLANK;
    endcase
  end

  // Frame loader: shift, commit validation, and tear-free swap at frame end
  always_comb begin
    shadow_d    = shadow_q;
    active_d    = active_q;
    bit_cnt_d   = bit_cnt_q;
    pending_d   = pending_q;
    frame_err_d = 1'b0;
    if (swap) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
      bit_cnt_d = '0;
    end else if (shift_ready_q && commit) begin
      if (bit_cnt_q == CNT_W'(FRAME_BITS)) begin
        pending_d = 1'b1;
      end else begin
        frame_err_d = 1'b1;
        bit_cnt_d   = '0;
      end
    end else if (shift_ready_q && shift_en) begin
      shadow_d = {shadow_q[FRAME_BITS-2:0], shift_data};
      if (bit_cnt_q != CNT_W'(FRAME_BITS + 1)) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
    shift_ready_d = ~pending_d;
  end

`ifdef LED_SCAN_BRIGHTNESS_EN
  logic [3:0]  brightness_q, brightness_d;
  logic [31:0] lit_limit;

  // Brightness is taken from the input during the frame_start cycle and held for the frame
  always_comb begin
    brightness_d = frame_start_q ? brightness : brightness_q;
    lit_limit    = ((32'(brightness_d) + 32'd1) * 32'(SCAN_DIV)) >> 4;
    lit          = (32'(dwell_cnt_d) < lit_limit);
  end

  // Brightness holding register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) brightness_q <= 4'hF;
    else        brightness_q <= brightness_d;
  end
`else
  assign lit = 1'b1;
`endif

  // Registered outputs are derived from the next scan state, so they change exactly at state boundaries
  always_comb begin
    row_d = '0;
    col_d = '0;
    sel   = SEL_W'(panel_idx_d) * SEL_W'(COLS) + SEL_W'(col_idx_d);
    if (state_d == S_ON && lit) begin
      col_d[sel] = 1'b1;
      for (int k = 0; k < NUM_COLS; k++) begin
        if (SEL_W'(k) == sel) row_d = active_q[k*ROWS +: ROWS];
      end
    end
  end

  // State, buffers and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_BLANK;
      panel_idx_q   <= '0;
      col_idx_q     <= '0;
      dwell_cnt_q   <= '0;
      blank_cnt_q   <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      bit_cnt_q     <= '0;
      pending_q     <= 1'b0;
      shift_ready_q <= 1'b1;
      frame_err_q   <= 1'b0;
      frame_start_q <= 1'b1;
      row_q         <= '0;
      col_q         <= '0;
    end else begin
      state_q       <= state_d;
      panel_idx_q   <= panel_idx_d;
      col_idx_q     <= col_idx_d;
      dwell_cnt_q   <= dwell_cnt_d;
      blank_cnt_q   <= blank_cnt_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      bit_cnt_q     <= bit_cnt_d;
      pending_q     <= pending_d;
      shift_ready_q <= shift_ready_d;
      frame_err_q   <= frame_err_d;
      frame_start_q <= frame_start_d;
      row_q         <= row_d;
      col_q         <= col_d;
    end
  end

  assign shift_ready = shift_ready_q;
  assign frame_err   = frame_err_q;
  assign frame_start = frame_start_q;
  assign row         = row_q;
  assign col         = col_q;

endmodule
